// File: rtl/tcdm_bank_arbiter.sv
// Round-robin arbiter sharing one single-cycle-latency BRAM bank port among
// NB_MASTERS TCDM requesters; the response is routed back to last cycle's winner.
module tcdm_bank_arbiter #(
  parameter int unsigned NB_MASTERS = 3,
  parameter int unsigned ADDR_WIDTH = 15,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BE_WIDTH   = DATA_WIDTH / 8
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [NB_MASTERS-1:0]            req_i,
  input  logic [NB_MASTERS-1:0]            wen_i,
  input  logic [NB_MASTERS*ADDR_WIDTH-1:0] add_i,
  input  logic [NB_MASTERS*BE_WIDTH-1:0]   be_i,
  input  logic [NB_MASTERS*DATA_WIDTH-1:0] wdata_i,
  output logic [NB_MASTERS-1:0]            gnt_o,
  output logic [NB_MASTERS-1:0]            r_valid_o,
  output logic [DATA_WIDTH-1:0]            r_rdata_o,
  output logic                             r_opc_o,
  output logic                             mem_en_o,
  output logic [BE_WIDTH-1:0]              mem_we_o,
  output logic [ADDR_WIDTH-3:0]            mem_addr_o,
  output logic [DATA_WIDTH-1:0]            mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]            mem_rdata_i
);

  localparam int unsigned IDX_W = (NB_MASTERS > 1) ? $clog2(NB_MASTERS) : 1;
  localparam int unsigned SUM_W = IDX_W + 1;

  logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [IDX_W-1:0]      resp_id_q, resp_id_d;

  logic                  any_gnt;
  logic [IDX_W-1:0]      win;
  logic [SUM_W-1:0]      cand_sum;
  logic [IDX_W-1:0]      cand;

  logic [ADDR_WIDTH-1:0] add_sel;
  logic [BE_WIDTH-1:0]   be_sel;
  logic [DATA_WIDTH-1:0] wdata_sel;
  logic                  wen_sel;
  logic                  add_lsb_unused;

  // Search from rr_ptr_q upward, wrapping; no grant is issued while in reset.
  always_comb begin
    any_gnt  = 1'b0;
    win      = '0;
    cand_sum = '0;
    cand     = '0;
    for (int unsigned k = 0; k < NB_MASTERS; k++) begin
      cand_sum = SUM_W'(rr_ptr_q) + SUM_W'(k);
      if (cand_sum >= SUM_W'(NB_MASTERS)) begin
        cand_sum = cand_sum - SUM_W'(NB_MASTERS);
      end
      cand = IDX_W'(cand_sum);
      if (rst_ni && !any_gnt && req_i[cand]) begin
        any_gnt = 1'b1;
        win     = cand;
      end
    end
  end

  // Winner payload mux onto the bank port; everything is zero without a winner.
  always_comb begin
    gnt_o     = '0;
    add_sel   = '0;
    be_sel    = '0;
    wdata_sel = '0;
    wen_sel   = 1'b1;
    for (int unsigned i = 0; i < NB_MASTERS; i++) begin
      if (any_gnt && (win == IDX_W'(i))) begin
        gnt_o[i]  = 1'b1;
        add_sel   = add_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        be_sel    = be_i[i*BE_WIDTH +: BE_WIDTH];
        wdata_sel = wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
        wen_sel   = wen_i[i];
      end
    end
    mem_en_o    = any_gnt;
    mem_addr_o  = add_sel[ADDR_WIDTH-1:2];
    mem_wdata_o = wdata_sel;
    mem_we_o    = wen_sel ? '0 : be_sel;
  end

  assign add_lsb_unused = ^add_sel[1:0];

  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    resp_valid_d = any_gnt;
    resp_id_d    = resp_id_q;
    if (any_gnt) begin
      rr_ptr_d  = (win == IDX_W'(NB_MASTERS - 1)) ? '0 : win + IDX_W'(1);
      resp_id_d = win;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
    end
  end

  // Response steering: read data is broadcast, valid goes to last cycle's winner.
  always_comb begin
    r_valid_o = '0;
    for (int unsigned i = 0; i < NB_MASTERS; i++) begin
      r_valid_o[i] = resp_valid_q && (resp_id_q == IDX_W'(i));
    end
  end

  assign r_rdata_o = mem_rdata_i;
  assign r_opc_o   = 1'b0;

endmodule

// File: tb/tb_tcdm_bank_arbiter.sv
// Directed bench for tcdm_bank_arbiter: a BRAM model on the bank port, a
// round-robin reference model checked every cycle, and literal expectations.
module tb_tcdm_bank_arbiter;

  localparam int N  = 3;
  localparam int AW = 15;
  localparam int DW = 32;
  localparam int BW = 4;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  logic [N-1:0]    m_req, m_wen;
  logic [AW-1:0]   m_add [N];
  logic [BW-1:0]   m_be  [N];
  logic [DW-1:0]   m_wd  [N];

  logic [N*AW-1:0] add_i;
  logic [N*BW-1:0] be_i;
  logic [N*DW-1:0] wdata_i;

  logic [N-1:0]    gnt_o, r_valid_o;
  logic [DW-1:0]   r_rdata_o, mem_wdata_o, bram_q;
  logic            r_opc_o, mem_en_o;
  logic [BW-1:0]   mem_we_o;
  logic [AW-3:0]   mem_addr_o;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      add_i[i*AW +: AW]   = m_add[i];
      be_i[i*BW +: BW]    = m_be[i];
      wdata_i[i*DW +: DW] = m_wd[i];
    end
  end

  tcdm_bank_arbiter #(
    .NB_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_i(m_req), .wen_i(m_wen), .add_i(add_i), .be_i(be_i), .wdata_i(wdata_i),
    .gnt_o(gnt_o), .r_valid_o(r_valid_o), .r_rdata_o(r_rdata_o), .r_opc_o(r_opc_o),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(bram_q)
  );

  function automatic logic [31:0] init_word(int a);
    return 32'h1000_0000 + 32'(a);
  endfunction

  // BRAM on the bank port: unwritten words read back as init_word(address).
  logic [31:0] bram [int];
  always @(posedge clk_i) begin : bram_blk
    int a;
    logic [31:0] word;
    if (mem_en_o) begin
      a = int'(mem_addr_o);
      word = bram.exists(a) ? bram[a] : init_word(a);
      bram_q <= word;
      for (int b = 0; b < BW; b++) begin
        if (mem_we_o[b]) word[b*8 +: 8] = mem_wdata_o[b*8 +: 8];
      end
      bram[a] = word;
    end
  end

  int checks = 0;
  int passed = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic int model_winner(logic [N-1:0] r, int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  // Reference model: pointer, pending response and the expected memory image.
  int          mptr;
  bit          pv, pread;
  int          pid;
  logic [31:0] prdata;
  logic [31:0] mmem [int];

  always @(posedge clk_i or negedge rst_ni) begin : model
    int w, a;
    logic [31:0] word;
    if (!rst_ni) begin
      mptr  <= 0;
      pv    <= 1'b0;
      pid   <= 0;
      pread <= 1'b0;
    end else begin
      w = model_winner(m_req, mptr);
      pv <= (w >= 0);
      if (w >= 0) begin
        a = int'(m_add[w][AW-1:2]);
        word = mmem.exists(a) ? mmem[a] : init_word(a);
        pid    <= w;
        pread  <= m_wen[w];
        prdata <= word;
        mptr   <= (w + 1) % N;
        if (!m_wen[w]) begin
          for (int b = 0; b < BW; b++) begin
            if (m_be[w][b]) word[b*8 +: 8] = m_wd[w][b*8 +: 8];
          end
          mmem[a] = word;
        end
      end
    end
  end

  always @(negedge clk_i) begin : cmp
    int w;
    logic [N-1:0]  eg, erv;
    logic [BW-1:0] ewe;
    logic [AW-3:0] eaddr;
    logic [DW-1:0] ewd;
    w = rst_ni ? model_winner(m_req, mptr) : -1;
    eg = '0; ewe = '0; eaddr = '0; ewd = '0;
    if (w >= 0) begin
      eg[w] = 1'b1;
      eaddr = m_add[w][AW-1:2];
      ewd   = m_wd[w];
      ewe   = m_wen[w] ? '0 : m_be[w];
    end
    erv = (rst_ni && pv) ? N'(1 << pid) : '0;
    chk("gnt",       32'(gnt_o),       32'(eg));
    chk("mem_en",    32'(mem_en_o),    32'(w >= 0));
    chk("mem_we",    32'(mem_we_o),    32'(ewe));
    chk("mem_addr",  32'(mem_addr_o),  32'(eaddr));
    chk("mem_wdata", mem_wdata_o,      ewd);
    chk("r_valid",   32'(r_valid_o),   32'(erv));
    chk("r_opc",     32'(r_opc_o),     32'd0);
    if (erv != '0 && pread) chk("r_rdata", r_rdata_o, prdata);
  end

  task automatic idle_all();
    m_req = '0;
    m_wen = '1;
    for (int i = 0; i < N; i++) begin
      m_add[i] = '0; m_be[i] = '0; m_wd[i] = '0;
    end
  endtask

  task automatic set_m(int i, logic wen, logic [AW-1:0] add, logic [BW-1:0] be, logic [DW-1:0] wd);
    m_req[i] = 1'b1; m_wen[i] = wen; m_add[i] = add; m_be[i] = be; m_wd[i] = wd;
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    idle_all();
    rst_ni = 1'b0;
    next_cycle();
    rst_ni = 1'b1;
  endtask

  logic [2:0] seq [6];

  initial begin
    seq = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    idle_all();
    m_req = 3'b111;
    @(negedge clk_i);
    chk("rst_gnt", 32'(gnt_o), 32'd0);
    chk("rst_mem_en", 32'(mem_en_o), 32'd0);
    chk("rst_r_valid", 32'(r_valid_o), 32'd0);
    next_cycle();
    idle_all();
    rst_ni = 1'b1;

    // Single read by master 1.
    set_m(1, 1'b1, 15'h0010, 4'hF, 32'h0);
    @(negedge clk_i);
    chk("t1_gnt", 32'(gnt_o), 32'b010);
    chk("t1_addr", 32'(mem_addr_o), 32'd4);
    chk("t1_we", 32'(mem_we_o), 32'd0);
    next_cycle();
    idle_all();
    @(negedge clk_i);
    chk("t1_r_valid", 32'(r_valid_o), 32'b010);
    chk("t1_rdata", r_rdata_o, 32'h1000_0004);
    next_cycle();

    // All masters request continuously.
    do_reset();
    for (int i = 0; i < N; i++) set_m(i, 1'b1, AW'(15'h0100 + 4 * i), 4'hF, 32'h0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk_i);
      chk("t2_gnt", 32'(gnt_o), 32'(seq[c]));
      chk("t2_r_valid", 32'(r_valid_o), (c == 0) ? 32'd0 : 32'(seq[c-1]));
      next_cycle();
    end
    idle_all();
    @(negedge clk_i);
    chk("t2_r_valid_tail", 32'(r_valid_o), 32'b100);
    next_cycle();

    // Partial write by master 0, read back by master 2.
    set_m(0, 1'b0, 15'h0020, 4'b0011, 32'hDEAD_BEEF);
    @(negedge clk_i);
    chk("t3_gnt_w", 32'(gnt_o), 32'b001);
    chk("t3_we", 32'(mem_we_o), 32'b0011);
    chk("t3_addr", 32'(mem_addr_o), 32'd8);
    next_cycle();
    idle_all();
    set_m(2, 1'b1, 15'h0020, 4'hF, 32'h0);
    @(negedge clk_i);
    chk("t3_gnt_r", 32'(gnt_o), 32'b100);
    next_cycle();
    idle_all();
    @(negedge clk_i);
    chk("t3_r_valid", 32'(r_valid_o), 32'b100);
    chk("t3_rdata", r_rdata_o, 32'h1000_BEEF);
    next_cycle();

    // Master 2 alone for four cycles.
    for (int c = 1; c <= 5; c++) begin
      idle_all();
      if (c <= 4) set_m(2, 1'b1, AW'(15'h0040 + 4 * c), 4'hF, 32'h0);
      @(negedge clk_i);
      chk("t4_gnt", 32'(gnt_o), (c <= 4) ? 32'b100 : 32'd0);
      chk("t4_r_valid", 32'(r_valid_o), (c >= 2) ? 32'b100 : 32'd0);
      next_cycle();
    end

    // Reset between a grant and its response.
    idle_all();
    set_m(0, 1'b1, 15'h0060, 4'hF, 32'h0);
    set_m(1, 1'b1, 15'h0064, 4'hF, 32'h0);
    @(negedge clk_i);
    chk("t5_gnt", 32'(gnt_o), 32'b001);
    #2 rst_ni = 1'b0;
    next_cycle();
    @(negedge clk_i);
    chk("t5_rst_r_valid", 32'(r_valid_o), 32'd0);
    chk("t5_rst_gnt", 32'(gnt_o), 32'd0);
    next_cycle();
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("t5_first_gnt", 32'(gnt_o), 32'b001);
    next_cycle();

    // Master 1 withdraws before it is ever granted.
    idle_all();
    set_m(2, 1'b1, 15'h0070, 4'hF, 32'h0);
    @(negedge clk_i);
    chk("t6_gnt_a", 32'(gnt_o), 32'b100);
    next_cycle();
    idle_all();
    set_m(0, 1'b1, 15'h0080, 4'hF, 32'h0);
    set_m(1, 1'b1, 15'h0090, 4'hF, 32'h0);
    @(negedge clk_i);
    chk("t6_gnt_b", 32'(gnt_o), 32'b001);
    chk("t6_addr_b", 32'(mem_addr_o), 32'h20);
    chk("t6_r_valid_b", 32'(r_valid_o), 32'b100);
    next_cycle();
    idle_all();
    set_m(0, 1'b1, 15'h0084, 4'hF, 32'h0);
    @(negedge clk_i);
    chk("t6_gnt_c", 32'(gnt_o), 32'b001);
    chk("t6_addr_c", 32'(mem_addr_o), 32'h21);
    chk("t6_r_valid_c", 32'(r_valid_o), 32'b001);
    next_cycle();
    idle_all();
    @(negedge clk_i);
    chk("t6_en_d", 32'(mem_en_o), 32'd0);
    chk("t6_r_valid_d", 32'(r_valid_o), 32'b001);
    next_cycle();
    @(negedge clk_i);
    chk("t6_r_valid_e", 32'(r_valid_o), 32'd0);
    next_cycle();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
